// File: rtl/controle_acesso_if.sv
// ----------------------------------------------------------------------------
// controle_acesso_if
//   Bundles the access controller's data-path signals: the assembled PIN frame
//   coming from the keypad PIN assembler, the door sensor, and the lock/status
//   outputs going to the actuator and LEDs.
//
//   pin_in       pinPac_t  {digit1,digit2,digit3,digit4,status}; 4'hF = digit
//                          not entered, status = frame valid
//   door_closed  1         door sensor, 1 = closed
//   unlock       1         lock actuator release
//   bloqueado    1         lockout active
//   prog_mode    1         waiting for a new user PIN
//   fail_count   FW        consecutive failures, saturates at MAX_TRIES
//   pin_ok       1         one-cycle pulse, PIN accepted
//   pin_err      1         one-cycle pulse, PIN rejected
//
//   master : PIN assembler / environment side (drives pin_in, door_closed)
//   slave  : access controller side
// ----------------------------------------------------------------------------
interface controle_acesso_if #(
    parameter int unsigned MAX_TRIES = 3
);
    localparam int unsigned FW = $clog2(MAX_TRIES + 1);

    typedef struct packed {
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
        logic       status;
    } pinPac_t;

    pinPac_t         pin_in;
    logic            door_closed;
    logic            unlock;
    logic            bloqueado;
    logic            prog_mode;
    logic [FW-1:0]   fail_count;
    logic            pin_ok;
    logic            pin_err;

    modport master (
        output pin_in,
        output door_closed,
        input  unlock,
        input  bloqueado,
        input  prog_mode,
        input  fail_count,
        input  pin_ok,
        input  pin_err
    );

    modport slave (
        input  pin_in,
        input  door_closed,
        output unlock,
        output bloqueado,
        output prog_mode,
        output fail_count,
        output pin_ok,
        output pin_err
    );
endinterface

// File: rtl/controle_acesso.sv
// ----------------------------------------------------------------------------
// controle_acesso
//   Door-lock access controller. Evaluates each new PIN frame once (on the
//   rising edge of pin_in.status) against the fixed master PIN and a
//   programmable user PIN, opens the lock for a timed window, counts
//   consecutive failures and enforces a timed lockout once MAX_TRIES failures
//   accumulate. The master PIN enters programming mode, where the next
//   complete frame (other than the master PIN) becomes the new user PIN.
//
//   clk   in  system clock
//   rst   in  asynchronous reset, active high
//   bus   controle_acesso_if.slave (pin_in, door_closed in; unlock,
//         bloqueado, prog_mode, fail_count, pin_ok, pin_err out)
//
//   All outputs are registered; a frame's result appears the cycle after its
//   status is first sampled high. One down-counting timer is shared by the
//   unlock window, the lockout and the programming timeout.
// ----------------------------------------------------------------------------
module controle_acesso #(
    parameter int unsigned MAX_TRIES        = 3,
    parameter int unsigned UNLOCK_CYCLES    = 5000,
    parameter int unsigned LOCKOUT_CYCLES   = 30000,
    parameter int unsigned PROG_TIMEOUT     = 10000,
    parameter logic [15:0] MASTER_PIN       = 16'h1234,
    parameter logic [15:0] DEFAULT_USER_PIN = 16'h0000
) (
    input logic              clk,
    input logic              rst,
    controle_acesso_if.slave bus
);

    localparam int unsigned FW = $clog2(MAX_TRIES + 1);

    localparam int unsigned T_UL_LO = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                                      UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned T_MAX   = (T_UL_LO > PROG_TIMEOUT) ?
                                      T_UL_LO : PROG_TIMEOUT;
    localparam int unsigned TW      = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] T_UNLOCK  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_PROG    = TW'(PROG_TIMEOUT - 1);
    localparam logic [FW-1:0] F_MAX     = FW'(MAX_TRIES);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_UNLOCKED = 2'd1;
    localparam logic [1:0] S_LOCKOUT  = 2'd2;
    localparam logic [1:0] S_PROG     = 2'd3;

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [FW-1:0] fail_q;
    logic [15:0]   user_pin;
    logic          status_q;

    logic          unlock_q;
    logic          bloqueado_q;
    logic          prog_mode_q;
    logic          pin_ok_q;
    logic          pin_err_q;

    // Frame decode
    logic          ev;
    logic [15:0]   pin;
    logic          incomplete;
    logic          is_master;
    logic          is_user;
    logic          timer_zero;
    logic [FW-1:0] fail_inc;

    always_comb begin
        ev         = bus.pin_in.status & ~status_q;
        pin        = {bus.pin_in.digit1, bus.pin_in.digit2,
                      bus.pin_in.digit3, bus.pin_in.digit4};
        incomplete = (bus.pin_in.digit1 == 4'hF) | (bus.pin_in.digit2 == 4'hF) |
                     (bus.pin_in.digit3 == 4'hF) | (bus.pin_in.digit4 == 4'hF);
        is_master  = (pin == MASTER_PIN);
        is_user    = (pin == user_pin);
        timer_zero = (timer == '0);
        fail_inc   = fail_q + FW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            fail_q      <= '0;
            user_pin    <= DEFAULT_USER_PIN;
            status_q    <= 1'b0;
            unlock_q    <= 1'b0;
            bloqueado_q <= 1'b0;
            prog_mode_q <= 1'b0;
            pin_ok_q    <= 1'b0;
            pin_err_q   <= 1'b0;
        end else begin
            status_q  <= bus.pin_in.status;
            pin_ok_q  <= 1'b0;
            pin_err_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (ev) begin
                        if (incomplete) begin
                            pin_err_q <= 1'b1;
                        end else if (is_master) begin
                            pin_ok_q    <= 1'b1;
                            fail_q      <= '0;
                            timer       <= T_PROG;
                            prog_mode_q <= 1'b1;
                            state       <= S_PROG;
                        end else if (is_user) begin
                            pin_ok_q <= 1'b1;
                            fail_q   <= '0;
                            timer    <= T_UNLOCK;
                            unlock_q <= 1'b1;
                            state    <= S_UNLOCKED;
                        end else begin
                            pin_err_q <= 1'b1;
                            fail_q    <= fail_inc;
                            if (fail_inc == F_MAX) begin
                                timer       <= T_LOCKOUT;
                                bloqueado_q <= 1'b1;
                                state       <= S_LOCKOUT;
                            end
                        end
                    end
                end

                // Timer parks at zero; the lock stays released until the door
                // is seen closed, so an open door never gets re-locked on it.
                S_UNLOCKED: begin
                    if (!timer_zero) begin
                        timer <= timer - TW'(1);
                    end else if (bus.door_closed) begin
                        unlock_q <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                S_LOCKOUT: begin
                    if (!timer_zero) begin
                        timer <= timer - TW'(1);
                    end else begin
                        bloqueado_q <= 1'b0;
                        fail_q      <= '0;
                        state       <= S_IDLE;
                    end
                end

                // A frame arriving on the timeout cycle is still evaluated.
                S_PROG: begin
                    if (ev) begin
                        if (!incomplete && !is_master) begin
                            user_pin <= pin;
                            pin_ok_q <= 1'b1;
                        end else begin
                            pin_err_q <= 1'b1;
                        end
                        prog_mode_q <= 1'b0;
                        state       <= S_IDLE;
                    end else if (timer_zero) begin
                        prog_mode_q <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                default: begin
                    unlock_q    <= 1'b0;
                    bloqueado_q <= 1'b0;
                    prog_mode_q <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.unlock     = unlock_q;
    assign bus.bloqueado  = bloqueado_q;
    assign bus.prog_mode  = prog_mode_q;
    assign bus.fail_count = fail_q;
    assign bus.pin_ok     = pin_ok_q;
    assign bus.pin_err    = pin_err_q;

endmodule

// File: tb/tb_controle_acesso.sv
// ----------------------------------------------------------------------------
// tb_controle_acesso
//   Directed bench for controle_acesso with short timers (unlock 8, lockout
//   16, programming timeout 20, three tries). Inputs change 1 ns after the
//   rising edge; outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_controle_acesso;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    controle_acesso_if #(.MAX_TRIES(3)) bus ();

    controle_acesso #(
        .MAX_TRIES      (3),
        .UNLOCK_CYCLES  (8),
        .LOCKOUT_CYCLES (16),
        .PROG_TIMEOUT   (20),
        .MASTER_PIN     (16'h1234),
        .DEFAULT_USER_PIN(16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a frame with status high for 'hold' edges, then drops status
    // for one edge; returns the pulses seen across all those edges.
    task automatic frame(input logic [15:0] pin, input int hold,
                         output int ok_c, output int err_c);
        ok_c  = 0;
        err_c = 0;
        bus.pin_in = {pin, 1'b1};
        for (int h = 0; h < hold; h++) begin
            tick();
            ok_c  += int'(bus.pin_ok);
            err_c += int'(bus.pin_err);
        end
        bus.pin_in.status = 1'b0;
        tick();
        ok_c  += int'(bus.pin_ok);
        err_c += int'(bus.pin_err);
    endtask

    task automatic wait_unlock_clear(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (!bus.unlock) break;
            tick();
        end
        check(tag, 32'(bus.unlock), 32'd0);
    endtask

    initial begin
        int ok_c;
        int err_c;
        int unl_c;
        int cnt;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.door_closed = 1'b1;
        bus.pin_in = {16'hFFFF, 1'b0};

        tick();
        tick();
        check("rst_unlock",    32'(bus.unlock),     32'd0);
        check("rst_bloqueado", 32'(bus.bloqueado),  32'd0);
        check("rst_prog",      32'(bus.prog_mode),  32'd0);
        check("rst_fail",      32'(bus.fail_count), 32'd0);
        check("rst_pulses",    32'({bus.pin_ok, bus.pin_err}), 32'd0);
        rst = 1'b0;
        tick();

        // 1: default user PIN, status held three cycles
        bus.pin_in = {16'h0000, 1'b1};
        tick();
        check("t1_ok_first", 32'(bus.pin_ok), 32'd1);
        check("t1_unlock_first", 32'(bus.unlock), 32'd1);
        ok_c  = int'(bus.pin_ok);
        err_c = int'(bus.pin_err);
        unl_c = int'(bus.unlock);
        for (int i = 2; i <= 12; i++) begin
            if (i == 4) bus.pin_in.status = 1'b0;
            tick();
            ok_c  += int'(bus.pin_ok);
            err_c += int'(bus.pin_err);
            unl_c += int'(bus.unlock);
        end
        check("t1_ok_count",  32'(ok_c),  32'd1);
        check("t1_err_count", 32'(err_c), 32'd0);
        check("t1_unlock_cycles", 32'(unl_c), 32'd8);
        check("t1_unlock_end", 32'(bus.unlock), 32'd0);
        check("t1_fail", 32'(bus.fail_count), 32'd0);

        // 2: three wrong PINs, lockout, frame ignored during lockout
        frame(16'h1111, 1, ok_c, err_c);
        check("t2_err1", 32'(err_c), 32'd1);
        check("t2_fail1", 32'(bus.fail_count), 32'd1);
        frame(16'h1111, 1, ok_c, err_c);
        check("t2_err2", 32'(err_c), 32'd1);
        check("t2_fail2", 32'(bus.fail_count), 32'd2);
        check("t2_bloq_before", 32'(bus.bloqueado), 32'd0);
        frame(16'h1111, 1, ok_c, err_c);
        check("t2_err3", 32'(err_c), 32'd1);
        check("t2_fail3", 32'(bus.fail_count), 32'd3);
        check("t2_bloq", 32'(bus.bloqueado), 32'd1);
        frame(16'h0000, 1, ok_c, err_c);
        check("t2_lock_pulses", 32'(ok_c + err_c), 32'd0);
        check("t2_lock_unlock", 32'(bus.unlock), 32'd0);
        check("t2_lock_fail", 32'(bus.fail_count), 32'd3);
        cnt = 4;
        while (bus.bloqueado && cnt < 40) begin
            tick();
            if (bus.bloqueado) cnt++;
        end
        check("t2_bloq_cycles", 32'(cnt), 32'd16);
        check("t2_bloq_end", 32'(bus.bloqueado), 32'd0);
        check("t2_fail_after", 32'(bus.fail_count), 32'd0);

        // 3: program user PIN 4-3-2-1
        frame(16'h1234, 1, ok_c, err_c);
        check("t3_master_ok", 32'(ok_c), 32'd1);
        check("t3_prog", 32'(bus.prog_mode), 32'd1);
        frame(16'h4321, 1, ok_c, err_c);
        check("t3_store_ok", 32'(ok_c), 32'd1);
        check("t3_store_err", 32'(err_c), 32'd0);
        check("t3_prog_off", 32'(bus.prog_mode), 32'd0);
        frame(16'h0000, 1, ok_c, err_c);
        check("t3_old_err", 32'(err_c), 32'd1);
        check("t3_old_unlock", 32'(bus.unlock), 32'd0);
        check("t3_old_fail", 32'(bus.fail_count), 32'd1);
        frame(16'h4321, 1, ok_c, err_c);
        check("t3_new_ok", 32'(ok_c), 32'd1);
        check("t3_new_unlock", 32'(bus.unlock), 32'd1);
        check("t3_new_fail", 32'(bus.fail_count), 32'd0);
        wait_unlock_clear("t3_unlock_clear");

        // 4: incomplete frames and programming timeout
        frame(16'h1111, 1, ok_c, err_c);
        check("t4_fail_pre", 32'(bus.fail_count), 32'd1);
        frame(16'hFF25, 1, ok_c, err_c);
        check("t4_inc_err", 32'(err_c), 32'd1);
        check("t4_inc_ok", 32'(ok_c), 32'd0);
        check("t4_inc_fail", 32'(bus.fail_count), 32'd1);
        frame(16'h1234, 1, ok_c, err_c);
        check("t4_prog", 32'(bus.prog_mode), 32'd1);
        check("t4_master_clears_fail", 32'(bus.fail_count), 32'd0);
        frame(16'hFF25, 1, ok_c, err_c);
        check("t4_prog_inc_err", 32'(err_c), 32'd1);
        check("t4_prog_inc_exit", 32'(bus.prog_mode), 32'd0);
        frame(16'h4321, 1, ok_c, err_c);
        check("t4_user_kept", 32'(bus.unlock), 32'd1);
        wait_unlock_clear("t4_unlock_clear");
        frame(16'h1234, 1, ok_c, err_c);
        check("t4_prog2", 32'(bus.prog_mode), 32'd1);
        cnt   = 2;
        ok_c  = 0;
        err_c = 0;
        while (bus.prog_mode && cnt < 40) begin
            tick();
            ok_c  += int'(bus.pin_ok);
            err_c += int'(bus.pin_err);
            if (bus.prog_mode) cnt++;
        end
        check("t4_prog_cycles", 32'(cnt), 32'd20);
        check("t4_timeout_pulses", 32'(ok_c + err_c), 32'd0);
        check("t4_timeout_fail", 32'(bus.fail_count), 32'd0);

        // 5: door held open at window expiry; frames ignored while unlocked
        frame(16'h4321, 1, ok_c, err_c);
        check("t5_unlock", 32'(bus.unlock), 32'd1);
        bus.door_closed = 1'b0;
        frame(16'h1111, 1, ok_c, err_c);
        check("t5_ignored_pulses", 32'(ok_c + err_c), 32'd0);
        check("t5_ignored_fail", 32'(bus.fail_count), 32'd0);
        for (int i = 0; i < 15; i++) tick();
        check("t5_held_open", 32'(bus.unlock), 32'd1);
        bus.door_closed = 1'b1;
        tick();
        check("t5_closed_relock", 32'(bus.unlock), 32'd0);

        // 6: reset mid-unlock discards the programmed PIN
        frame(16'h1234, 1, ok_c, err_c);
        frame(16'h4321, 1, ok_c, err_c);
        check("t6_reprog_ok", 32'(ok_c), 32'd1);
        frame(16'h4321, 1, ok_c, err_c);
        check("t6_unlock", 32'(bus.unlock), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_unlock", 32'(bus.unlock), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        frame(16'h0000, 1, ok_c, err_c);
        check("t6_default_ok", 32'(ok_c), 32'd1);
        check("t6_default_unlock", 32'(bus.unlock), 32'd1);
        wait_unlock_clear("t6_unlock_clear");
        frame(16'h4321, 1, ok_c, err_c);
        check("t6_old_err", 32'(err_c), 32'd1);
        check("t6_old_fail", 32'(bus.fail_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
